if_id_pipe_reg: RTL and testbench



---
 rtl/if_id_pipe_reg.sv | 62 ++++++
 tb/tb_if_id_pipe_reg.sv | 138 +++++++++++++
 2 files changed

// File: rtl/if_id_pipe_reg.sv
// =============================================================================
// Module      : if_id_pipe_reg
// Description : IF/ID pipeline register with stall (hold) and flush (bubble).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module if_id_pipe_reg #(
  parameter int                 INSTR_W   = 19,
  parameter int                 PC_W      = 8,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 19'h00000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] IF_instruction,
  input  logic [PC_W-1:0]    IF_pc_plus_one,
  input  logic               IF_IDwrite,
  input  logic               IF_flush,
  output logic [INSTR_W-1:0] ID_instruction,
  output logic [PC_W-1:0]    ID_pc_plus_one,
  output logic               ID_valid
);

  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               valid_q, valid_d;

  // Flush outranks the write enable so a bubble still lands during a stall.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (IF_flush) begin
      instr_d = NOP_INSTR;
      pc_d    = '0;
      valid_d = 1'b0;
    end else if (IF_IDwrite) begin
      instr_d = IF_instruction;
      pc_d    = IF_pc_plus_one;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign ID_instruction = instr_q;
  assign ID_pc_plus_one = pc_q;
  assign ID_valid       = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_if_id_pipe_reg.sv
// =============================================================================
// Module      : tb_if_id_pipe_reg
// Description : Directed self-checking bench for if_id_pipe_reg.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_if_id_pipe_reg;

  localparam int INSTR_W = 19;
  localparam int PC_W    = 8;

  logic               clk;
  logic               rst;
  logic [INSTR_W-1:0] IF_instruction;
  logic [PC_W-1:0]    IF_pc_plus_one;
  logic               IF_IDwrite;
  logic               IF_flush;
  logic [INSTR_W-1:0] ID_instruction;
  logic [PC_W-1:0]    ID_pc_plus_one;
  logic               ID_valid;

  int n_checks = 0;
  int n_passed = 0;

  if_id_pipe_reg #(
    .INSTR_W  (INSTR_W),
    .PC_W     (PC_W),
    .NOP_INSTR(19'h00000)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .IF_instruction(IF_instruction),
    .IF_pc_plus_one(IF_pc_plus_one),
    .IF_IDwrite    (IF_IDwrite),
    .IF_flush      (IF_flush),
    .ID_instruction(ID_instruction),
    .ID_pc_plus_one(ID_pc_plus_one),
    .ID_valid      (ID_valid)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_passed++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_outs(input string tag, input logic [INSTR_W-1:0] e_instr,
                          input logic [PC_W-1:0] e_pc, input logic e_valid);
    chk({tag, ".instr"}, 32'(ID_instruction), 32'(e_instr));
    chk({tag, ".pc"},    32'(ID_pc_plus_one), 32'(e_pc));
    chk({tag, ".valid"}, 32'(ID_valid),       32'(e_valid));
  endtask

  // Check 1 after the edge, then leave the caller at edge+5 to drive inputs.
  task automatic tick_chk(input string tag, input logic [INSTR_W-1:0] e_instr,
                          input logic [PC_W-1:0] e_pc, input logic e_valid);
    @(posedge clk);
    #1;
    chk_outs(tag, e_instr, e_pc, e_valid);
    #4;
  endtask

  task automatic drive(input logic r, input logic w, input logic f,
                       input logic [INSTR_W-1:0] instr, input logic [PC_W-1:0] pc);
    rst            = r;
    IF_IDwrite     = w;
    IF_flush       = f;
    IF_instruction = instr;
    IF_pc_plus_one = pc;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 19'h7ABCD, 8'h5A);
    #5;

    // Reset, then stall with nonzero inputs keeps reset values
    tick_chk("reset", 19'h00000, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 19'h7ABCD, 8'h5A);
    tick_chk("post_reset_hold", 19'h00000, 8'h00, 1'b0);

    // Capture two patterns
    drive(1'b0, 1'b1, 1'b0, 19'h55555, 8'hFF);
    tick_chk("cap_55555", 19'h55555, 8'hFF, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 19'h2AAAA, 8'hAA);
    tick_chk("cap_2AAAA", 19'h2AAAA, 8'hAA, 1'b1);

    // Stall for three edges, then release
    drive(1'b0, 1'b0, 1'b0, 19'h7FFFF, 8'h01);
    for (int i = 0; i < 3; i++) tick_chk("stall_hold", 19'h2AAAA, 8'hAA, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 19'h7FFFF, 8'h01);
    tick_chk("stall_release", 19'h7FFFF, 8'h01, 1'b1);

    // Flush during a stall inserts a bubble
    drive(1'b0, 1'b0, 1'b1, 19'h0F0F0, 8'h77);
    tick_chk("flush_over_stall", 19'h00000, 8'h00, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 19'h13579, 8'h24);
    tick_chk("after_flush", 19'h13579, 8'h24, 1'b1);

    // Flush also wins over an active write
    drive(1'b0, 1'b1, 1'b1, 19'h3C3C3, 8'h99);
    tick_chk("flush_over_write", 19'h00000, 8'h00, 1'b0);

    // Reset outranks write
    drive(1'b0, 1'b1, 1'b0, 19'h00001, 8'h80);
    tick_chk("pre_rst_cap", 19'h00001, 8'h80, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 19'h12345, 8'h42);
    tick_chk("rst_priority", 19'h00000, 8'h00, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 19'h12345, 8'h42);
    tick_chk("after_rst", 19'h12345, 8'h42, 1'b1);

    // Input and reset changes between edges do not reach the outputs
    drive(1'b0, 1'b1, 1'b0, 19'h0ABCD, 8'h33);
    tick_chk("timing_cap", 19'h0ABCD, 8'h33, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 19'h1F0F0, 8'hC3);
    #3;
    chk_outs("mid_cycle_inputs", 19'h0ABCD, 8'h33, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 19'h7FFFF, 8'hFF);
    #2;
    chk_outs("mid_cycle_inputs2", 19'h0ABCD, 8'h33, 1'b1);
    tick_chk("timing_last_wins", 19'h7FFFF, 8'hFF, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 19'h7FFFF, 8'hFF);
    #3;
    chk_outs("mid_cycle_rst", 19'h7FFFF, 8'hFF, 1'b1);
    tick_chk("rst_at_edge", 19'h00000, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 19'h11111, 8'h11);
    tick_chk("final_hold", 19'h00000, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
